fifo_rd_arbiter: RTL and testbench
==================================

# fifo_rd_arbiter

Round-robin arbiter that shares the read port of the async FIFO between several consumers in the read clock domain. A consumer requests a burst of N words; the arbiter grants one consumer at a time and drives the FIFO read enable while the FIFO is not empty. It steers the returned words to the granted consumer and signals burst completion. It sits between the FIFO read-pointer/memory logic and the read-side consumers.

## Interface
- NUM_REQ, 4, number of consumers (2..8)
- DATA_WIDTH, 32, FIFO word width
- LEN_WIDTH, 4, burst length field width; burst = len+1 words (1..2^LEN_WIDTH)

- r_clk  in  1  read-domain clock
- rrst  in  1  reset, asynchronous, active-high
- req  in  NUM_REQ  per-consumer burst request, level
- req_len  in  NUM_REQ*LEN_WIDTH  per-consumer len, slice i = bits [i*LEN_WIDTH +: LEN_WIDTH]
- f_empty  in  1  FIFO empty flag from read-pointer logic
- r_data  in  DATA_WIDTH  FIFO read data, valid one cycle after an accepted r_en
- r_en  out  1  FIFO read enable
- gnt  out  NUM_REQ  one-hot grant, held for whole burst
- rd_data  out  DATA_WIDTH  word to consumers (r_data passed through)
- rd_valid  out  NUM_REQ  one-hot, marks rd_data for granted consumer
- rd_done  out  NUM_REQ  one-cycle pulse with last word of burst
- busy  out  1  high in any state other than IDLE

## Operation
- States: IDLE, BURST, DRAIN.
- IDLE:
  - If any req bit is set, pick the winner by round-robin. Search starts at the priority pointer and proceeds upward, wrapping modulo NUM_REQ.
  - Register gnt for the winner and latch cnt = req_len[winner].
  - Set the priority pointer to winner+1, wrapping to 0 at NUM_REQ.
  - Go to BURST.
  - If no req bit is set, stay in IDLE.
- BURST:
  - r_en = !f_empty; r_en is combinational from state and f_empty.
  - On each cycle with r_en=1: if cnt==0 go to DRAIN, else cnt <= cnt-1.
  - When f_empty=1, hold state and cnt; r_en=0.
- DRAIN:
  - r_en=0.
  - Last word arrives; rd_done[winner]=1 for this cycle.
  - gnt clears; next state is IDLE.
- rd_valid = r_en_d & gnt, where r_en_d is r_en registered. gnt is still asserted in DRAIN, so the last word is tagged correctly.
- A consumer dropping req mid-burst is ignored; the burst always completes the latched length.
- A consumer must keep req low in the cycle after its rd_done if it wants no new burst.
- Consumers cannot stall; every rd_valid word must be accepted.
- r_en never asserts while f_empty=1. This gives empty protection independent of the FIFO's own gating.
- cnt is LEN_WIDTH bits. No wrap is possible because cnt stops at 0.

## Timing
- Reset (rrst=1, asynchronous) forces all of the following:
  - state=IDLE, cnt=0, priority pointer=0, r_en_d=0.
  - gnt=0, r_en=0, rd_valid=0, rd_done=0, busy=0.
- Reset mid-burst aborts the burst; no rd_done is issued. The FIFO pointer keeps the words already read.
- Request to grant: req sampled in IDLE at edge k gives gnt high from k (registered) and r_en possible in the same cycle.
- Read to data: r_en at cycle t gives rd_valid/rd_data at cycle t+1.
- Throughput: 1 word/cycle while not empty.
- Overhead: a burst of L words with FIFO never empty takes L+2 cycles from grant to next grant: L BURST cycles, 1 DRAIN cycle, 1 IDLE cycle.
- Simultaneous requests are resolved strictly by the round-robin pointer.
- A newly asserted req during a burst waits for the next IDLE.

## Test plan
- Single burst: reset, FIFO holds 8 words, req[1]=1 with len=3.
  - gnt=0010 one cycle later.
  - r_en high 4 consecutive cycles.
  - rd_valid[1] on the 4 following cycles with data in FIFO order.
  - rd_done[1] with the 4th word; gnt=0 next cycle.
- Round-robin: req=1111 held, all len=0, FIFO full.
  - Grants in order 0001, 0010, 0100, 1000, 0001.
  - Each grant lasts 2 cycles, with 1 IDLE cycle between grants.
- Empty stall: req[2] with len=5, FIFO holds 2 words, then 4 more written 10 cycles later.
  - r_en for 2 cycles, then 0 while f_empty=1; busy stays 1.
  - Remaining 4 words are read after f_empty falls.
  - rd_done[2] follows the 6th word.
- Pointer wrap and fairness: after a grant to 3, with req=1001, the next grant is 0. After a grant to 0, with req=1001, the next grant is 3.
- Req dropped mid-burst: req[0] with len=7 deasserted after 2 words. All 8 words are still delivered and rd_done[0] still pulses.
- Reset mid-burst: assert rrst during the 3rd read cycle of a len=7 burst.
  - All outputs go 0 immediately; no rd_done.
  - After release, req[3] alone is granted and the priority pointer restarts at 0.

Source files
------------

// File: rtl/fifo_rd_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fifo_rd_arbiter_if : FIFO read port and consumer bus for the arbiter |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface fifo_rd_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 4
);
  logic [NUM_REQ-1:0]           req;
  logic [NUM_REQ*LEN_WIDTH-1:0] req_len;
  logic                         f_empty;
  logic [DATA_WIDTH-1:0]        r_data;
  logic                         r_en;
  logic [NUM_REQ-1:0]           gnt;
  logic [DATA_WIDTH-1:0]        rd_data;
  logic [NUM_REQ-1:0]           rd_valid;
  logic [NUM_REQ-1:0]           rd_done;
  logic                         busy;

  modport master (
    input  req, req_len, f_empty, r_data,
    output r_en, gnt, rd_data, rd_valid, rd_done, busy
  );

  modport slave (
    output req, req_len, f_empty, r_data,
    input  r_en, gnt, rd_data, rd_valid, rd_done, busy
  );
endinterface
`default_nettype wire

// File: rtl/fifo_rd_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fifo_rd_arbiter : round-robin burst arbiter on the async FIFO read   |
// | port; steers returned words to the granted consumer. Rev 1.0         |
// +----------------------------------------------------------------------+
module fifo_rd_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 4
) (
  input  logic                r_clk,
  input  logic                rrst,
  fifo_rd_arbiter_if.master   bus_io
);
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [LEN_WIDTH-1:0] cnt_q, cnt_d;
  logic [PTR_W-1:0]     ptr_q, ptr_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic                 ren_q;

  logic [NUM_REQ-1:0]   w_req_rot;
  logic                 w_found;
  int                   w_off;
  int                   w_sum;
  logic [PTR_W-1:0]     w_win;
  logic [PTR_W-1:0]     w_ptr_nxt;
  logic [NUM_REQ-1:0]   w_win_oh;
  logic [LEN_WIDTH-1:0] w_len;
  logic                 w_r_en;
  logic [NUM_REQ-1:0]   w_done;

  // Rotate requests so bit 0 is the consumer at the priority pointer.
  always_comb begin
    w_req_rot = NUM_REQ'({bus_io.req, bus_io.req} >> ptr_q);
    w_found   = 1'b0;
    w_off     = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!w_found && w_req_rot[i]) begin
        w_found = 1'b1;
        w_off   = i;
      end
    end
    w_sum = int'(ptr_q) + w_off;
    if (w_sum >= NUM_REQ) begin
      w_sum = w_sum - NUM_REQ;
    end
    w_win     = PTR_W'(w_sum);
    w_ptr_nxt = (w_win == PTR_W'(NUM_REQ - 1)) ? '0 : w_win + 1'b1;
  end

  always_comb begin
    w_win_oh = '0;
    w_len    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_win == PTR_W'(i)) begin
        w_win_oh[i] = 1'b1;
        w_len       = bus_io.req_len[i*LEN_WIDTH +: LEN_WIDTH];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    w_r_en  = 1'b0;
    w_done  = '0;
    case (state_q)
      ST_IDLE: begin
        if (w_found) begin
          gnt_d   = w_win_oh;
          cnt_d   = w_len;
          ptr_d   = w_ptr_nxt;
          state_d = ST_BURST;
        end
      end
      ST_BURST: begin
        // Never read an empty FIFO, regardless of the FIFO's own gating.
        w_r_en = !bus_io.f_empty;
        if (w_r_en) begin
          if (cnt_q == '0) begin
            state_d = ST_DRAIN;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        w_done  = gnt_q;
        gnt_d   = '0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge r_clk or posedge rrst) begin
    if (rrst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ptr_q   <= '0;
      gnt_q   <= '0;
      ren_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      ren_q   <= w_r_en;
    end
  end

  // gnt is still held in DRAIN, so the final word is tagged to its owner.
  assign bus_io.r_en     = w_r_en;
  assign bus_io.gnt      = gnt_q;
  assign bus_io.rd_data  = bus_io.r_data;
  assign bus_io.rd_valid = {NUM_REQ{ren_q}} & gnt_q;
  assign bus_io.rd_done  = w_done;
  assign bus_io.busy     = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_fifo_rd_arbiter.sv
`default_nettype none
// Bench for fifo_rd_arbiter: FIFO environment, transaction-level reference
// model (words remaining per burst, round-robin pointer), directed + random.
module tb_fifo_rd_arbiter;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int LW = 4;

  logic r_clk = 1'b0;
  logic rrst;
  always #5 r_clk = ~r_clk;

  fifo_rd_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) bus ();

  fifo_rd_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .r_clk  (r_clk),
    .rrst   (rrst),
    .bus_io (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] mirror_q[$];
  logic [N-1:0]  gnt_log[$];
  logic [N-1:0]  prev_gnt;
  int            words_got[N];
  int            done_got[N];

  bit m_busy;
  int m_win;
  int m_ptr;
  int m_left;
  bit m_ren_exp;
  bit d_ren;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int rr_pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) begin
      int c;
      c = (p + k) % N;
      if ((r & (N'(1) << c)) != '0) return c;
    end
    return 0;
  endfunction

  task automatic push_words(input int n);
    logic [DW-1:0] w;
    for (int k = 0; k < n; k++) begin
      w = $urandom;
      fifo_q.push_back(w);
      mirror_q.push_back(w);
    end
  endtask

  task automatic clear_stats();
    for (int k = 0; k < N; k++) begin
      words_got[k] = 0;
      done_got[k]  = 0;
    end
    gnt_log.delete();
  endtask

  task automatic tick();
    logic [N-1:0]    req_s;
    logic [N*LW-1:0] len_s;
    logic [N-1:0]    oh;
    logic [DW-1:0]   exp_data;
    bit              arrive;
    bus.f_empty = (fifo_q.size() == 0);
    #1;
    m_ren_exp = m_busy && (m_left > 0) && !bus.f_empty && !rrst;
    d_ren     = bus.r_en;
    chk("r_en", 64'(d_ren), 64'(m_ren_exp));
    req_s = bus.req;
    len_s = bus.req_len;
    @(posedge r_clk);
    #1;
    if (d_ren) begin
      if (fifo_q.size() > 0) bus.r_data = fifo_q.pop_front();
      else                   bus.r_data = '1;
    end
    arrive = 1'b0;
    if (!rrst) begin
      if (!m_busy) begin
        if (req_s != '0) begin
          m_win  = rr_pick(req_s, m_ptr);
          m_ptr  = (m_win + 1) % N;
          m_left = int'(LW'(len_s >> (m_win * LW))) + 1;
          m_busy = 1'b1;
        end
      end else if (m_ren_exp) begin
        m_left--;
        arrive = 1'b1;
      end else if (m_left == 0) begin
        m_busy = 1'b0;
      end
    end
    bus.f_empty = (fifo_q.size() == 0);
    #1;
    oh = m_busy ? (N'(1) << m_win) : '0;
    chk("gnt",      64'(bus.gnt),      64'(oh));
    chk("busy",     64'(bus.busy),     64'(m_busy));
    chk("rd_valid", 64'(bus.rd_valid), 64'(arrive ? oh : '0));
    chk("rd_done",  64'(bus.rd_done),  64'((arrive && m_left == 0) ? oh : '0));
    if (arrive) begin
      exp_data = (mirror_q.size() > 0) ? mirror_q.pop_front() : '0;
      chk("rd_data", 64'(bus.rd_data), 64'(exp_data));
    end
    for (int k = 0; k < N; k++) begin
      if (bus.rd_valid[k] === 1'b1) words_got[k]++;
      if (bus.rd_done[k] === 1'b1)  done_got[k]++;
    end
    if (prev_gnt == '0 && bus.gnt != '0) gnt_log.push_back(bus.gnt);
    prev_gnt = bus.gnt;
  endtask

  task automatic do_reset();
    rrst = 1'b1;
    #1;
    chk("rst_gnt",      64'(bus.gnt),      64'(0));
    chk("rst_r_en",     64'(bus.r_en),     64'(0));
    chk("rst_rd_valid", 64'(bus.rd_valid), 64'(0));
    chk("rst_rd_done",  64'(bus.rd_done),  64'(0));
    chk("rst_busy",     64'(bus.busy),     64'(0));
    m_busy    = 1'b0;
    m_ptr     = 0;
    m_left    = 0;
    m_ren_exp = 1'b0;
    mirror_q  = fifo_q;
    prev_gnt  = '0;
    tick();
    rrst = 1'b0;
    clear_stats();
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 100; k++) begin
      if (!m_busy && bus.busy === 1'b0) break;
      if (fifo_q.size() == 0) push_words(1);
      tick();
    end
    chk("idle_timeout", 64'(bus.busy), 64'(0));
  endtask

  logic [N-1:0] rr_exp[5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [N-1:0] wrap_exp[3] = '{4'b1000, 4'b0001, 4'b1000};

  initial begin
    rrst        = 1'b0;
    bus.req     = '0;
    bus.req_len = '0;
    bus.r_data  = '0;
    bus.f_empty = 1'b1;
    prev_gnt    = '0;
    m_busy      = 1'b0;
    m_ptr       = 0;
    m_left      = 0;
    m_win       = 0;
    m_ren_exp   = 1'b0;
    clear_stats();
    #2;
    do_reset();

    // Single burst: consumer 1, four words.
    push_words(8);
    bus.req     = 4'b0010;
    bus.req_len = {4'd0, 4'd0, 4'd3, 4'd0};
    tick();
    bus.req = '0;
    wait_idle();
    chk("single_words", 64'(words_got[1]), 64'(4));
    chk("single_done",  64'(done_got[1]),  64'(1));
    chk("single_gnt0",  64'(gnt_log.size() > 0 ? gnt_log[0] : '0), 64'(4'b0010));

    // Round-robin with all consumers requesting single words.
    do_reset();
    push_words(16);
    bus.req     = 4'b1111;
    bus.req_len = '0;
    repeat (15) tick();
    bus.req = '0;
    wait_idle();
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("rr_order%0d", k),
          64'(k < gnt_log.size() ? gnt_log[k] : '0), 64'(rr_exp[k]));
    end

    // Empty stall in mid-burst, refill after ten cycles.
    do_reset();
    push_words(2);
    bus.req     = 4'b0100;
    bus.req_len = {4'd0, 4'd5, 4'd0, 4'd0};
    tick();
    bus.req = '0;
    repeat (10) tick();
    push_words(4);
    wait_idle();
    chk("stall_words", 64'(words_got[2]), 64'(6));
    chk("stall_done",  64'(done_got[2]),  64'(1));

    // Pointer wrap from 3 back to 0 and fairness between 0 and 3.
    do_reset();
    push_words(16);
    bus.req     = 4'b1000;
    bus.req_len = '0;
    tick();
    bus.req = 4'b1001;
    repeat (6) tick();
    bus.req = '0;
    wait_idle();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("wrap_order%0d", k),
          64'(k < gnt_log.size() ? gnt_log[k] : '0), 64'(wrap_exp[k]));
    end

    // Request dropped after two words; full burst still completes.
    do_reset();
    push_words(10);
    bus.req     = 4'b0001;
    bus.req_len = {4'd0, 4'd0, 4'd0, 4'd7};
    tick();
    repeat (2) tick();
    bus.req = '0;
    wait_idle();
    chk("drop_words", 64'(words_got[0]), 64'(8));
    chk("drop_done",  64'(done_got[0]),  64'(1));

    // Reset during the third read cycle, then consumer 3 alone.
    do_reset();
    push_words(16);
    bus.req     = 4'b0001;
    bus.req_len = {4'd0, 4'd0, 4'd0, 4'd7};
    repeat (3) tick();
    bus.req = 4'b1000;
    do_reset();
    chk("rst_mid_no_done", 64'(done_got[0]), 64'(0));
    bus.req_len = {4'd2, 4'd0, 4'd0, 4'd0};
    tick();
    bus.req = '0;
    wait_idle();
    chk("rst_mid_gnt3",  64'(gnt_log.size() > 0 ? gnt_log[0] : '0), 64'(4'b1000));
    chk("rst_mid_words", 64'(words_got[3]), 64'(3));
    chk("rst_mid_done0", 64'(done_got[0]),  64'(0));

    // Random traffic against the reference model.
    do_reset();
    for (int c = 0; c < 800; c++) begin
      if (fifo_q.size() < 20 && $urandom_range(0, 2) != 0) push_words(int'($urandom_range(1, 2)));
      bus.req     = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom);
      bus.req_len = (N*LW)'($urandom);
      tick();
    end
    bus.req = '0;
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
